// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0]  req_len;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;
  logic                  tx_enable;
  logic                  tx_load;
  logic [31:0]           tx_data;
  logic                  tx_comp;
  logic                  err;

  modport slave (
    input  req, req_data, req_len, tx_comp,
    output gnt, done, busy, tx_enable, tx_load, tx_data, err
  );

  modport master (
    output req, req_data, req_len, tx_comp,
    input  gnt, done, busy, tx_enable, tx_load, tx_data, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among NUM_REQ word senders
// Optional per-byte watchdog: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = 868,
  parameter int TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || BAUD_DIV < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      baud_cnt;
  logic               tick;
  logic               comp_q;
  logic               comp_rise;
  logic [GW-1:0]      rr_ptr;
  logic [GW-1:0]      g_idx;
  logic [31:0]        shift_reg;
  logic [1:0]         bytes_left;
  logic [NUM_REQ-1:0] gnt_r;
  logic [NUM_REQ-1:0] done_r;
  logic               tx_load_r;
  logic [31:0]        tx_data_r;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;

  assign tick          = (baud_cnt == CW'(BAUD_DIV - 1));
  assign comp_rise     = bus.tx_comp & ~comp_q;
  assign bus.tx_enable = tick;
  assign bus.busy      = (state != IDLE);
  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.tx_load   = tx_load_r;
  assign bus.tx_data   = tx_data_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
      comp_q   <= 1'b0;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
      comp_q   <= bus.tx_comp;
    end
  end

  // First requester after the last winner, wrapping, so the last winner is lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_valid && bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tick_cnt;
  logic          err_r;
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt_r      <= '0;
      done_r     <= '0;
      tx_load_r  <= 1'b0;
      tx_data_r  <= '0;
      shift_reg  <= '0;
      bytes_left <= '0;
      rr_ptr     <= GW'(NUM_REQ - 1);
      g_idx      <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tick_cnt   <= '0;
      err_r      <= 1'b0;
`endif
    end else begin
      done_r <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      err_r  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            g_idx      <= pick_idx;
            gnt_r      <= NUM_REQ'(1) << pick_idx;
            shift_reg  <= bus.req_data[32*int'(pick_idx) +: 32];
            bytes_left <= bus.req_len[2*int'(pick_idx) +: 2];
            tx_load_r  <= 1'b1;
            tx_data_r  <= {24'b0, bus.req_data[32*int'(pick_idx) +: 8]};
            state      <= LOAD;
          end
        end
        LOAD: begin
          // uart_tx only samples load on a baud tick
          if (tick) begin
            tx_load_r <= 1'b0;
            state     <= WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tick_cnt  <= '0;
`endif
          end
        end
        WAIT: begin
          if (comp_rise) begin
            if (bytes_left == 2'd0) begin
              done_r <= gnt_r;
              state  <= DONE;
            end else begin
              shift_reg  <= shift_reg >> 8;
              bytes_left <= bytes_left - 2'd1;
              tx_load_r  <= 1'b1;
              tx_data_r  <= {24'b0, shift_reg[15:8]};
              state      <= LOAD;
            end
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (tick) begin
            if (tick_cnt == TW'(TIMEOUT - 1)) begin
              err_r  <= 1'b1;
              done_r <= gnt_r;
              state  <= DONE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
        end
        DONE: begin
          gnt_r  <= '0;
          rr_ptr <= g_idx;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int BD = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(.NUM_REQ(NR), .BAUD_DIV(BD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int side_bad = 0;
  int load_accepts = 0;
  int err_count = 0;
  int ticks_at_err = 0;
  int err_tick_age = 0;
  int cyc = 0;
  int last_tick_cyc = 0;
  bit comp_stuck = 1'b0;
  int rr_model = NR - 1;
  logic [7:0]  byte_q[$];
  int          grant_q[$];
  logic [7:0]  exp_bytes[$];
  int          exp_grants[$];
  logic [31:0] data_v[NR];
  logic [1:0]  len_v[NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural uart_tx: frame takes 10 bit ticks after load is sampled, then comp rises.
  initial begin : uart_model
    bit active;
    int ticks;
    logic [NR-1:0] prev_gnt;
    active = 1'b0;
    ticks = 0;
    prev_gnt = '0;
    bus.tx_comp = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        bus.tx_comp = 1'b0;
        active = 1'b0;
        ticks = 0;
      end else begin
        if (bus.tx_load && bus.tx_enable) load_accepts++;
        if (active) begin
          if (bus.tx_enable) begin
            ticks++;
            if (ticks == 10 && !comp_stuck) begin
              bus.tx_comp = 1'b1;
              active = 1'b0;
            end
          end
        end else if (bus.tx_load && bus.tx_enable) begin
          active = 1'b1;
          ticks = 0;
          bus.tx_comp = 1'b0;
          byte_q.push_back(bus.tx_data[7:0]);
          if (bus.tx_data[31:8] !== 24'd0) side_bad++;
        end
        if (bus.gnt != 0 && prev_gnt == 0)
          for (int i = 0; i < NR; i++) if (bus.gnt[i]) grant_q.push_back(i);
        if ((bus.gnt & (bus.gnt - 1'b1)) != 0) side_bad++;
        if (bus.busy !== (bus.gnt != 0)) side_bad++;
        if (bus.done != 0 && bus.done !== bus.gnt) side_bad++;
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (bus.err) begin
          err_count++;
          ticks_at_err = ticks;
          err_tick_age = cyc - last_tick_cyc;
          if (bus.done == 0) side_bad++;
        end
`else
        if (bus.err !== 1'b0) side_bad++;
`endif
        if (bus.tx_enable) last_tick_cyc = cyc;
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic drive_words();
    for (int i = 0; i < NR; i++) begin
      bus.req_data[32*i +: 32] = data_v[i];
      bus.req_len[2*i +: 2]    = len_v[i];
    end
  endtask

  task automatic wait_done(input bit scramble, output int idx);
    bit scrambled;
    idx = -1;
    scrambled = 1'b0;
    for (int c = 0; c < 2000 && idx < 0; c++) begin
      @(negedge clk);
      // Words are latched at grant, so late changes must not reach tx_data.
      if (scramble && !scrambled && bus.gnt != 0) begin
        for (int i = 0; i < NR; i++)
          if (bus.gnt[i]) begin
            bus.req_data[32*i +: 32] = $urandom;
            bus.req_len[2*i +: 2]    = 2'($urandom_range(0, 3));
          end
        scrambled = 1'b1;
      end
      if (bus.done != 0)
        for (int i = 0; i < NR; i++) if (bus.done[i]) idx = i;
    end
    if (idx < 0) chk("done_timeout", 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic run_round(input logic [NR-1:0] mask, input int n_done, input bit hold);
    logic [NR-1:0] pend;
    int exp_g;
    int seen;
    pend = mask;
    byte_q.delete();
    grant_q.delete();
    exp_bytes.delete();
    exp_grants.delete();
    drive_words();
    bus.req = mask;
    for (int n = 0; n < n_done; n++) begin
      exp_g = -1;
      for (int k = 1; k <= NR; k++)
        if (exp_g < 0 && pend[(rr_model + k) % NR]) exp_g = (rr_model + k) % NR;
      exp_grants.push_back(exp_g);
      for (int b = 0; b <= int'(len_v[exp_g]); b++) exp_bytes.push_back(data_v[exp_g][8*b +: 8]);
      wait_done(!hold, seen);
      chk("done_index", seen, exp_g);
      rr_model = exp_g;
      if (!hold) begin
        pend[exp_g] = 1'b0;
        bus.req[exp_g] = 1'b0;
      end
    end
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("gnt_after", {28'd0, bus.gnt}, 32'd0);
    chk("byte_count", byte_q.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < byte_q.size(); i++)
      chk($sformatf("byte%0d", i), {24'd0, byte_q[i]}, {24'd0, exp_bytes[i]});
    chk("grant_count", grant_q.size(), exp_grants.size());
    for (int i = 0; i < exp_grants.size() && i < grant_q.size(); i++)
      chk($sformatf("grant%0d", i), grant_q[i], exp_grants[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rr_model = NR - 1;
  endtask

  initial begin
    logic [9:0] frame;
    int seen;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_len = '0;
    for (int i = 0; i < NR; i++) begin data_v[i] = '0; len_v[i] = '0; end

    repeat (3) @(negedge clk);
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_done", {28'd0, bus.done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_tx_enable", {31'd0, bus.tx_enable}, 32'd0);
    chk("rst_tx_load", {31'd0, bus.tx_load}, 32'd0);
    chk("rst_tx_data", bus.tx_data, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    reset = 1'b0;

    // Baud tick after the k-th edge following release lands when k mod BD == BD-1.
    for (int k = 1; k <= 5 * BD; k++) begin
      @(negedge clk);
      chk($sformatf("baud_k%0d", k), {31'd0, bus.tx_enable}, {31'd0, (k % BD) == BD - 1});
    end

    data_v[0] = 32'h0000_00A5; len_v[0] = 2'd0;
    run_round(4'b0001, 1, 1'b0);
    frame = 10'd0;
    if (byte_q.size() > 0) frame = {1'b1, byte_q[0], 1'b0};
    chk("frame_a5", {22'd0, frame}, 32'h34A);

    data_v[2] = 32'h4433_2211; len_v[2] = 2'd3;
    run_round(4'b0100, 1, 1'b0);

    do_reset();
    for (int i = 0; i < NR; i++) begin data_v[i] = $urandom; len_v[i] = 2'd0; end
    run_round(4'b1111, 6, 1'b1);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NR; i++) begin
        data_v[i] = $urandom;
        len_v[i]  = 2'($urandom_range(0, 3));
      end
      run_round(4'($urandom_range(1, 15)), 0, 1'b0);
    end
    for (int r = 0; r < 4; r++) begin
      logic [NR-1:0] m;
      int cnt;
      m = 4'($urandom_range(1, 15));
      cnt = 0;
      for (int i = 0; i < NR; i++) if (m[i]) cnt++;
      for (int i = 0; i < NR; i++) begin
        data_v[i] = $urandom;
        len_v[i]  = 2'($urandom_range(0, 3));
      end
      run_round(m, cnt, 1'b0);
    end

    // Reset while byte 2 of 4 is on the wire, then a fresh transaction from byte 0.
    do_reset();
    data_v[1] = 32'h4433_2211; len_v[1] = 2'd3;
    drive_words();
    byte_q.delete();
    bus.req = 4'b0010;
    for (int c = 0; c < 2000 && byte_q.size() < 2; c++) @(negedge clk);
    chk("mid_bytes_seen", byte_q.size(), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_tx_load", {31'd0, bus.tx_load}, 32'd0);
    chk("mid_rst_tx_data", bus.tx_data, 32'd0);
    chk("mid_rst_done", {28'd0, bus.done}, 32'd0);
    reset = 1'b0;
    rr_model = NR - 1;
    run_round(4'b0010, 1, 1'b0);

`ifdef UART_TX_ARB_TIMEOUT_EN
    do_reset();
    comp_stuck = 1'b1;
    load_accepts = 0;
    err_count = 0;
    data_v[0] = 32'h1122_3344; len_v[0] = 2'd3;
    drive_words();
    bus.req = 4'b0001;
    wait_done(1'b0, seen);
    chk("to_done_idx", seen, 32'd0);
    chk("to_err_with_done", {31'd0, bus.err}, 32'd1);
    bus.req = '0;
    repeat (100) @(negedge clk);
    chk("to_err_count", err_count, 32'd1);
    chk("to_ticks", ticks_at_err, TO);
    chk("to_tick_age", err_tick_age, 32'd1);
    chk("to_loads", load_accepts, 32'd1);
    chk("to_busy", {31'd0, bus.busy}, 32'd0);
    comp_stuck = 1'b0;
    do_reset();
`endif

    chk("side_checks", side_bad, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1);
  end
endmodule
